// File: rtl/adc128s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc128s_pkg
// Description : Shared constants, types and the channel reset-value helper
//               for the ADC128S-style SPI ADC behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
package adc128s_pkg;

  localparam int DATA_W     = 12;
  localparam int NUM_CH     = 8;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_MSB   = 13;
  localparam int ADDR_LSB   = 11;

  localparam logic [DATA_W-1:0] INIT_BASE = 12'h100;
  localparam logic [DATA_W-1:0] INIT_STEP = 12'h200;

  typedef logic [2:0]        chan_t;
  typedef logic [DATA_W-1:0] sample_t;

  // Power-on conversion value of a channel: ch0=0x100, ch1=0x300 ... ch7=0xF00.
  function automatic sample_t init_val(input chan_t ch);
    return INIT_BASE + sample_t'(ch) * INIT_STEP;
  endfunction

endpackage : adc128s_pkg
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_sync
// Description : Two-flop synchronizer for an asynchronous SPI line plus a
//               history flop that yields single-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync #(
  parameter logic IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  // Shift the raw line through the metastability pair and the edge history.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // Reset to the idle level so no edge is reported coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      hist_q  <= IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~hist_q;
  assign fall  = ~sync2_q & hist_q;

endmodule : spi_edge_sync
`default_nettype wire

// File: rtl/adc128s_spi.sv
`default_nettype none
// ============================================================================
// Module      : adc128s_spi
// Description : Behavioural SPI slave model of an 8-channel 12-bit ADC128S.
//               Each completed 16-bit frame returns the channel addressed by
//               the previous frame, then bumps that channel's value by INC.
//               Optional macro ADC128S_TRISTATE_EN floats MISO while the
//               slave is deselected; otherwise MISO is driven low.
// Revision    : 1.0 - initial release
// ============================================================================
module adc128s_spi
  import adc128s_pkg::*;
#(
  parameter sample_t INC = 12'h010
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;

  logic mosi_s1_q, mosi_s1_d;
  logic mosi_s2_q, mosi_s2_d;

  logic                  active_q,    active_d;
  logic [4:0]            bit_cnt_q,   bit_cnt_d;
  chan_t                 cur_ch_q,    cur_ch_d;
  chan_t                 ch_ptr_q,    ch_ptr_d;
  // Only the 13 newest MOSI bits are kept: older ones are never inspected.
  logic [ADDR_MSB-1:0]   shift_in_q,  shift_in_d;
  // Bits still to be sent after the current MISO bit, next one at the MSB.
  logic [FRAME_BITS-2:0] shift_out_q, shift_out_d;
  logic                  miso_q,      miso_d;
  sample_t               val_q [NUM_CH];
  sample_t               val_d [NUM_CH];

  logic [FRAME_BITS-1:0] start_word;

  spi_edge_sync #(.IDLE(1'b1)) u_ss_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (SS_n),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_edge_sync #(.IDLE(1'b1)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (SCLK),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // MOSI needs only the metastability pair; it is sampled on synced SCLK rise.
  always_comb begin
    mosi_s1_d = MOSI;
    mosi_s2_d = mosi_s1_q;
  end

  // Frame sequencing: start, abort/deselect, bit capture and bit launch.
  always_comb begin
    active_d    = active_q;
    bit_cnt_d   = bit_cnt_q;
    cur_ch_d    = cur_ch_q;
    ch_ptr_d    = ch_ptr_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    miso_d      = miso_q;
    val_d       = val_q;
    start_word  = {{(FRAME_BITS - DATA_W){1'b0}}, val_q[ch_ptr_q]};

    if (ss_fall) begin
      cur_ch_d    = ch_ptr_q;
      shift_out_d = start_word[FRAME_BITS-2:0];
      miso_d      = start_word[FRAME_BITS-1];
      bit_cnt_d   = '0;
      active_d    = 1'b1;
    end else if (ss_rise) begin
      // Deselect wins over any coincident SCLK edge; an unfinished frame
      // leaves the address pointer and channel values untouched.
      active_d = 1'b0;
      miso_d   = 1'b0;
    end else if (active_q && !ss_lvl) begin
      // Level qualifiers keep edge decodes consistent with the synced levels.
      if (sclk_rise && sclk_lvl && bit_cnt_q <= LAST_BIT) begin
        shift_in_d = {shift_in_q[ADDR_MSB-2:0], mosi_s2_q};
        bit_cnt_d  = bit_cnt_q + 5'd1;
        if (bit_cnt_q == LAST_BIT) begin
          // The incoming bit lands at word[0], so the address field sits one
          // position lower in the register than in the finished word.
          ch_ptr_d        = shift_in_q[ADDR_MSB-1:ADDR_LSB-1];
          val_d[cur_ch_q] = val_q[cur_ch_q] + INC;
          miso_d          = 1'b0;
        end
      end else if (sclk_fall && !sclk_lvl && bit_cnt_q != 5'd0 && bit_cnt_q <= LAST_BIT) begin
        miso_d      = shift_out_q[FRAME_BITS-2];
        shift_out_d = {shift_out_q[FRAME_BITS-3:0], 1'b0};
      end
    end
  end

  // State registers; reset restores every channel to its power-on value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      active_q    <= 1'b0;
      bit_cnt_q   <= '0;
      cur_ch_q    <= '0;
      ch_ptr_q    <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      miso_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        val_q[i] <= init_val(chan_t'(i));
      end
    end else begin
      mosi_s1_q   <= mosi_s1_d;
      mosi_s2_q   <= mosi_s2_d;
      active_q    <= active_d;
      bit_cnt_q   <= bit_cnt_d;
      cur_ch_q    <= cur_ch_d;
      ch_ptr_q    <= ch_ptr_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      miso_q      <= miso_d;
      val_q       <= val_d;
    end
  end

`ifdef ADC128S_TRISTATE_EN
  assign MISO = ss_lvl ? 1'bz : miso_q;
`else
  assign MISO = miso_q;
`endif

endmodule : adc128s_spi
`default_nettype wire

// File: tb/tb_adc128s_spi.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc128s_spi
// Description : Directed self-checking bench for adc128s_spi (mode-3 master
//               with 5-clock SCLK phases). Honours ADC128S_TRISTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc128s_spi;

  logic clk = 1'b0;
  logic rst;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  wire  MISO;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ADC128S_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  adc128s_spi #(.INC(12'h010)) dut (
    .clk  (clk),
    .rst  (rst),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI transaction of nclk SCLK cycles; MISO is sampled just before
  // each rising edge, the same instant a real master would capture it.
  task automatic frame(input logic [15:0] mo, input int nclk,
                       output logic [15:0] word, output logic [3:0] extra);
    word  = '0;
    extra = '0;
    SS_n  = 1'b0;
    tick(6);
    for (int i = 0; i < nclk; i++) begin
      SCLK = 1'b0;
      if (i < 16) MOSI = mo[15-i];
      else        MOSI = 1'b0;
      tick(5);
      if (i < 16) word[15-i] = MISO;
      else        extra = {extra[2:0], MISO};
      SCLK = 1'b1;
      tick(5);
    end
    tick(3);
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick(8);
    check("idle_miso", {15'd0, MISO}, {15'd0, IDLE_MISO});
  endtask

  logic [15:0] w;
  logic [3:0]  ex;

  initial begin
    rst  = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    tick(3);
    check("rst_miso", {15'd0, MISO}, {15'd0, IDLE_MISO});
    rst = 1'b0;
    tick(4);

    // Pointer starts at ch0; address 3 is taken for the next frame.
    frame(16'h1800, 16, w, ex); check("f1_ch0_init", w, 16'h0100);
    frame(16'h0000, 16, w, ex); check("f2_ch3_init", w, 16'h0700);
    frame(16'h0000, 16, w, ex); check("f3_ch0_inc1", w, 16'h0110);
    frame(16'h2800, 16, w, ex); check("f4_ch0_inc2", w, 16'h0120);

    // Aborted frame toward ch7: first byte of ch5 visible, nothing committed.
    frame(16'h3800, 8, w, ex);  check("abort_hi_byte", {8'd0, w[15:8]}, 16'h000B);
    frame(16'h3800, 16, w, ex); check("f5_ch5_noinc", w, 16'h0B00);

    // Seventeen reads of ch7 walk 0xF00..0xFF0 then wrap to 0x000.
    for (int k = 0; k < 17; k++) begin
      frame(16'h3800, 16, w, ex);
      check($sformatf("ch7_read%0d", k), w, 16'((12'hF00 + 12'(k * 16)) & 12'hFFF));
    end

    // Over-clocked frame: bits past 16 read zero, single commit (addr 2).
    frame(16'h1000, 20, w, ex);
    check("extra_word", w, 16'h0010);
    check("extra_bits", {12'd0, ex}, 16'h0000);
    frame(16'h3800, 16, w, ex); check("ch2_init", w, 16'h0500);
    frame(16'h1800, 16, w, ex); check("ch7_once", w, 16'h0020);

    // Reset mid-frame while ch3 (0x710) is being shifted out.
    SS_n = 1'b0;
    tick(6);
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b0; tick(5);
      SCLK = 1'b1; tick(5);
    end
    SCLK = 1'b0;
    tick(5);
    check("pre_rst_bit9", {15'd0, MISO}, 16'h0001);
    rst = 1'b1;
    tick(1);
    check("mid_rst_miso", {15'd0, MISO}, {15'd0, IDLE_MISO});
    rst  = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b1;
    tick(8);

    frame(16'h0000, 16, w, ex); check("post_rst_ch0", w, 16'h0100);
    frame(16'h1800, 16, w, ex); check("post_rst_ch0b", w, 16'h0110);
    frame(16'h0000, 16, w, ex); check("post_rst_ch3", w, 16'h0700);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_adc128s_spi
`default_nettype wire
